// File: rtl/ex_operand_stage.sv
// Operand-fetch stage ahead of the ALU: register file with write-back bypass,
// pending-write scoreboard for RAW/WAW stalls, and a single-entry output register.
module ex_operand_stage #(
   parameter int Data_Width    = 32,
   parameter int Address_Width = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [Address_Width-1:0] rs1,
   input  logic [Address_Width-1:0] rs2,
   input  logic [Address_Width-1:0] rd,
   input  logic [Data_Width-1:0]    imm,
   input  logic                     op2_sel,
   input  logic [3:0]               ALU_ctrl_in,
   input  logic                     reg_write_in,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [Data_Width-1:0]    op1,
   output logic [Data_Width-1:0]    op2,
   output logic [3:0]               ALU_ctrl,
   output logic [Address_Width-1:0] rd_out,
   output logic                     reg_write_out,
   input  logic                     wb_en,
   input  logic [Address_Width-1:0] wb_addr,
   input  logic [Data_Width-1:0]    wb_data,
   input  logic                     flush,
   output logic [Data_Width-1:0]    a0
);

   localparam int NumRegs = 1 << Address_Width;

   logic [Data_Width-1:0] regs [NumRegs];
   logic [NumRegs-1:0]    pending;
   logic [NumRegs-1:0]    pending_next;
   logic                  byp1, byp2, wb_clears_rd;
   logic                  hazard, accept;
   logic [Data_Width-1:0] rs1_val, rs2_val;

   // A write-back landing this cycle both forwards its data and satisfies any
   // outstanding dependency on that register, so stalls end in the wb cycle.
   always_comb begin
      byp1         = wb_en && (wb_addr == rs1) && (rs1 != '0);
      byp2         = wb_en && (wb_addr == rs2) && (rs2 != '0);
      wb_clears_rd = wb_en && (wb_addr == rd);
      rs1_val      = (rs1 == '0) ? '0 : (byp1 ? wb_data : regs[rs1]);
      rs2_val      = (rs2 == '0) ? '0 : (byp2 ? wb_data : regs[rs2]);
      hazard       = (pending[rs1] && !byp1)
                  || (!op2_sel && pending[rs2] && !byp2)
                  || (reg_write_in && (rd != '0) && pending[rd] && !wb_clears_rd);
   end

   assign in_ready = rst && !flush && !hazard && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;
   assign a0       = regs[Address_Width'(10)];

   // Clears are applied before the set so a same-cycle set of the same bit wins.
   always_comb begin
      pending_next = pending;
      if (wb_en)
         pending_next[wb_addr] = 1'b0;
      if (flush && out_valid && reg_write_out && (rd_out != '0))
         pending_next[rd_out] = 1'b0;
      if (accept && reg_write_in && (rd != '0))
         pending_next[rd] = 1'b1;
      pending_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst)
         pending <= '0;
      else
         pending <= pending_next;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NumRegs; i++)
            regs[i] <= '0;
      end else if (wb_en && (wb_addr != '0)) begin
         regs[wb_addr] <= wb_data;
      end
   end

   // Data registers only move on accept, so they stay bit-stable under back-pressure.
   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid     <= 1'b0;
         op1           <= '0;
         op2           <= '0;
         ALU_ctrl      <= '0;
         rd_out        <= '0;
         reg_write_out <= 1'b0;
      end else if (accept) begin
         out_valid     <= 1'b1;
         op1           <= rs1_val;
         op2           <= op2_sel ? imm : rs2_val;
         ALU_ctrl      <= ALU_ctrl_in;
         rd_out        <= rd;
         reg_write_out <= reg_write_in;
      end else if (flush || out_ready) begin
         out_valid     <= 1'b0;
      end
   end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

Operand-fetch stage that sits directly upstream of the ALU. Reads the 32-entry register file, selects op2 (register or immediate), and applies write-back bypass. Detects read-after-write and write-after-write hazards with a per-register pending scoreboard. Registers op1/op2/ALU_ctrl into a single-entry valid/ready output stage that drives the ALU inputs.

## Interface
- Data_Width, 32, operand/register width
- Address_Width, 5, register index width (32 registers)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle
- rs1, rs2  in  Address_Width  source register indices
- rd  in  Address_Width  destination index
- imm  in  Data_Width  sign-extended immediate
- op2_sel  in  1  1 = op2 from imm, 0 = op2 from rs2
- ALU_ctrl_in  in  4  ALU operation, passed through unchanged
- reg_write_in  in  1  instruction writes rd
- out_valid  out  1  op1/op2/ALU_ctrl valid for ALU
- out_ready  in  1  downstream consumes output
- op1, op2  out  Data_Width  ALU operands
- ALU_ctrl  out  4  registered ALU operation
- rd_out  out  Address_Width  registered rd
- reg_write_out  out  1  registered reg_write_in
- wb_en  in  1  write-back strobe
- wb_addr  in  Address_Width  write-back index
- wb_data  in  Data_Width  write-back value
- flush  in  1  discard instruction held in output stage
- a0  out  Data_Width  contents of register x10 (debug/result)

## Operation
- Register file: 32 x Data_Width. x0 reads 0 always; writes to x0 ignored. Written at clock edge when wb_en && wb_addr != 0.
- Read bypass: if wb_en && wb_addr == rsN && rsN != 0, the read of rsN returns wb_data in the same cycle.
- Scoreboard: pending[31:0], with pending[0] constant 0.
  - Set bit rd on accept when reg_write_in && rd != 0.
  - Clear bit wb_addr on wb_en.
  - Same register set and cleared in the same cycle: set wins.
- Hazard (blocks acceptance):
  - pending[rs1] and not bypassed this cycle.
  - op2_sel == 0, pending[rs2] and not bypassed this cycle.
  - reg_write_in, rd != 0, pending[rd] and not cleared by a write-back this cycle (WAW).
- in_ready = !rst_active && !flush && !hazard && (!out_valid || out_ready).
- accept = in_valid && in_ready.
- On accept, load op1 = rs1 value, op2 = op2_sel ? imm : rs2 value, ALU_ctrl, rd_out, reg_write_out; set out_valid = 1.
- No accept but out_ready: out_valid = 0, data registers hold their values.
- Back-pressure: while out_valid && !out_ready, all outputs are held bit-stable.
- Flush:
  - Sets out_valid = 0 next cycle.
  - If the held instruction has out_valid && reg_write_out && rd_out != 0, clears pending[rd_out], unless a set of the same bit occurs that cycle (impossible, since in_ready = 0 during flush).
  - No acceptance in the flush cycle.
  - Write-backs in the flush cycle still complete.
- a0 = register x10 array contents (no bypass).
- Reset (rst == 0 at an edge):
  - out_valid = 0; op1 = op2 = 0; ALU_ctrl = 0; rd_out = 0; reg_write_out = 0.
  - pending = 0; all registers = 0, so a0 = 0.
  - Reset overrides wb_en, accept and flush in the same cycle. in_ready = 0 while rst == 0.

## Timing
- Latency: accept at edge N, so operands are valid on out_valid after edge N.
- Throughput: 1 instruction/cycle when out_ready is held high and there are no hazards.
- Write-back at edge N is readable combinationally in cycle N via bypass, and from the array after edge N.
- A hazard stall lasts until the producing write-back cycle. The dependent instruction is accepted in that same write-back cycle using bypassed data.
- in_ready is combinational from in_valid-independent state, pending, wb_*, flush and out_ready. It never depends on in_valid.
- Mid-operation reset: a pending stall or held output is discarded at the first edge with rst == 0.

## Test plan
- Reset then read: wb x5 = 0x0000_0007, then issue rs1 = 5, op2_sel = 1, imm = 3, ALU_ctrl = 0000 -> one cycle later out_valid = 1, op1 = 7, op2 = 3, ALU_ctrl = 0000.
- x0 rule: wb x0 = 0xFFFF_FFFF, issue rs1 = 0, rs2 = 0, op2_sel = 0 -> op1 = 0, op2 = 0.
- RAW stall and bypass: issue rd = 6 with reg_write_in = 1; next, issue rs1 = 6 -> in_ready = 0 for 3 cycles. In cycle 4 apply wb x6 = 0x1234 -> accepted that cycle, op1 = 0x1234.
- Back-pressure: out_ready = 0 for 4 cycles with in_valid = 1 -> in_ready = 0 and op1/op2/ALU_ctrl unchanged. Drop out_ready low then raise it -> next instruction accepted in the same cycle out_ready = 1.
- Flush: held instruction with rd = 9, reg_write_out = 1; assert flush -> out_valid = 0 next cycle and pending[9] = 0. A following rs1 = 9 issue is accepted immediately with the array value.
- WAW and reset: two writers to rd = 4 -> second stalls until wb x4. Assert rst = 0 mid-stall -> out_valid = 0, pending = 0, a0 = 0 after the edge.
